// File: rtl/sram_pkg.sv
// Shared defaults and FSM state encoding for the SRAM request controller.
package sram_pkg;
  localparam int ADDR_WIDTH_DEF = 4;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int RD_LAT_DEF     = 2;
  localparam int CNT_W          = 3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETUP    = 2'd1,
    WR_PULSE = 2'd2,
    RD_WAIT  = 2'd3
  } state_e;
endpackage

// File: rtl/sram_resp_buf.sv
// One-entry read response register with valid/ready on both sides.
module sram_resp_buf #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data
);
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  assign in_ready  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  // A capture on the same edge as a drain keeps the entry valid.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_valid) begin
      valid_d = 1'b1;
      data_d  = in_data;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end
endmodule

// File: rtl/sram_req_ctrl.sv
// Sequences single-word SRAM reads and writes from a valid/ready request port
// and returns read data through a one-entry response buffer.
module sram_req_ctrl
  import sram_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int RD_LAT     = RD_LAT_DEF
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_din,
  output logic                  sram_we_n,
  input  logic [DATA_WIDTH-1:0] sram_dout
);
  state_e                state_q, state_d;
  logic                  wr_q, wr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic                  we_n_q, we_n_d;
  logic                  rdy_en_q;
  logic                  buf_in_ready;
  logic                  capture;
  logic                  accept;

  // resp_ready is the only unregistered term so a drain and a new request
  // can share one edge; nothing from the inputs reaches the sram_* pins.
  assign req_ready = rdy_en_q && (state_q == IDLE) && buf_in_ready;
  assign accept    = req_valid && req_ready;
  assign sram_addr = addr_q;
  assign sram_din  = din_q;
  assign sram_we_n = we_n_q;

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    din_d   = din_q;
    we_n_d  = 1'b1;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SETUP;
          addr_d  = req_addr;
          wr_d    = req_wr;
          if (req_wr) din_d = req_wdata;
        end
      end
      SETUP: begin
        if (wr_q) begin
          state_d = WR_PULSE;
          we_n_d  = 1'b0;
        end else begin
          state_d = RD_WAIT;
          cnt_d   = CNT_W'(RD_LAT - 1);
        end
      end
      WR_PULSE: state_d = IDLE;
      RD_WAIT: begin
        if (cnt_q == '0) begin
          capture = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= IDLE;
      wr_q     <= 1'b0;
      cnt_q    <= '0;
      addr_q   <= '0;
      din_q    <= '0;
      we_n_q   <= 1'b1;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_q     <= wr_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      we_n_q   <= we_n_d;
      rdy_en_q <= 1'b1;
    end
  end

  sram_resp_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_resp_buf (
    .clk      (clk),
    .rstn     (rstn),
    .in_valid (capture),
    .in_ready (buf_in_ready),
    .in_data  (sram_dout),
    .out_valid(resp_valid),
    .out_ready(resp_ready),
    .out_data (resp_rdata)
  );
endmodule
